// File: rtl/mpu6050_pkg.sv
// Shared definitions for the MPU6050 I2C target model: default address,
// register map names, FSM state encoding and the bus event bundle.
package mpu6050_pkg;

    localparam logic [6:0] DEV_ADDR_DEFAULT   = 7'h68;
    localparam logic [6:0] WHOAMI_REG_DEFAULT = 7'h75;

    localparam logic [6:0] ACCEL_XOUT_H = 7'h3B;
    localparam logic [6:0] PWR_MGMT_1   = 7'h6B;

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_ADDR     = 4'd1;
    localparam logic [3:0] ST_ADDR_ACK = 4'd2;
    localparam logic [3:0] ST_PTR      = 4'd3;
    localparam logic [3:0] ST_PTR_ACK  = 4'd4;
    localparam logic [3:0] ST_WR_BYTE  = 4'd5;
    localparam logic [3:0] ST_WR_ACK   = 4'd6;
    localparam logic [3:0] ST_RD_BYTE  = 4'd7;
    localparam logic [3:0] ST_RD_ACK   = 4'd8;
    localparam logic [3:0] ST_WAIT     = 4'd9;

    typedef struct packed {
        logic start;
        logic stop;
        logic rise;
        logic fall;
        logic sda;
    } bus_evt_t;

    function automatic logic addr_match(input logic [7:0] rx, input logic [6:0] dev);
        return rx[7:1] == dev;
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Brings SCL/SDA into the MCLK domain and turns them into single-cycle
// START, STOP, SCL-rise and SCL-fall pulses plus the synchronised SDA level.
module i2c_bus_sync
    import mpu6050_pkg::*;
(
    input  logic     mclk,
    input  logic     reset,
    input  logic     scl,
    input  logic     sda,
    output bus_evt_t evt
);

    // Stage 0/1 form the synchroniser, stage 2 holds the previous level for edge detection
    logic [2:0] scl_sync;
    logic [2:0] sda_sync;

    // Shift both pins through three flops; reset to the idle-bus level so no false edge appears
    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            scl_sync <= 3'b111;
            sda_sync <= 3'b111;
        end else begin
            scl_sync <= {scl_sync[1:0], scl};
            sda_sync <= {sda_sync[1:0], sda};
        end
    end

    // START/STOP need SCL high on both samples so a data change near an SCL edge is not mistaken for one
    always_comb begin
        evt.rise  = scl_sync[1] & ~scl_sync[2];
        evt.fall  = ~scl_sync[1] & scl_sync[2];
        evt.start = scl_sync[1] & scl_sync[2] & sda_sync[2] & ~sda_sync[1];
        evt.stop  = scl_sync[1] & scl_sync[2] & ~sda_sync[2] & sda_sync[1];
        evt.sda   = sda_sync[1];
    end

endmodule

// File: rtl/mpu6050_i2c_target.sv
// MPU6050-style I2C target: address match and ACK, register pointer with
// auto-increment, byte writes into a local register file and burst reads
// out of it. SDA is driven open-drain via sda_oe; SCL is never stretched.
module mpu6050_i2c_target
    import mpu6050_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR   = DEV_ADDR_DEFAULT,
    parameter int         AW         = 7,
    parameter logic [6:0] WHOAMI_REG = WHOAMI_REG_DEFAULT
) (
    input  logic          mclk,
    input  logic          reset,
    input  logic          scl,
    input  logic          sda_in,
    output logic          sda_oe,
    input  logic          upd_en,
    input  logic [AW-1:0] upd_addr,
    input  logic [7:0]    upd_data,
    output logic          wr_stb,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    output logic          busy
);

    localparam int            DEPTH      = 1 << AW;
    localparam logic [AW-1:0] WHOAMI_IDX = AW'(WHOAMI_REG);
    localparam logic [7:0]    WHOAMI_VAL = 8'(DEV_ADDR);

    bus_evt_t      evt;
    logic [3:0]    state;
    logic [3:0]    bit_cnt;
    logic [7:0]    shift;
    logic [7:0]    rd_shift;
    logic [AW-1:0] ptr;
    logic          rw;
    logic          master_ack;
    logic [7:0]    regfile [DEPTH];

    logic [7:0]    rx_byte;
    logic [7:0]    rd_val;
    logic          bus_we;

    i2c_bus_sync u_sync (
        .mclk  (mclk),
        .reset (reset),
        .scl   (scl),
        .sda   (sda_in),
        .evt   (evt)
    );

    // Byte being completed on this rise, the byte a read would present, and the bus write strobe
    always_comb begin
        rx_byte = {shift[6:0], evt.sda};
        rd_val  = (ptr == WHOAMI_IDX) ? WHOAMI_VAL : regfile[ptr];
        bus_we  = (state == ST_WR_BYTE) && evt.rise && (bit_cnt == 4'd7);
    end

    // Register file: local updates first, then the bus write so it wins on an address collision
    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regfile[i] <= 8'h00;
            end
        end else begin
            if (upd_en && (upd_addr != WHOAMI_IDX)) begin
                regfile[upd_addr] <= upd_data;
            end
            if (bus_we && (ptr != WHOAMI_IDX)) begin
                regfile[ptr] <= rx_byte;
            end
        end
    end

    // Protocol FSM: bits are counted on SCL rises, state changes and SDA drive happen on SCL falls
    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            bit_cnt    <= 4'd0;
            shift      <= 8'h00;
            rd_shift   <= 8'h00;
            ptr        <= '0;
            rw         <= 1'b0;
            master_ack <= 1'b0;
            sda_oe     <= 1'b0;
            wr_stb     <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= 8'h00;
            busy       <= 1'b0;
        end else begin
            wr_stb <= 1'b0;
            if (evt.stop) begin
                state   <= ST_IDLE;
                bit_cnt <= 4'd0;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
            end else if (evt.start) begin
                state   <= ST_ADDR;
                bit_cnt <= 4'd0;
                sda_oe  <= 1'b0;
            end else begin
                if (evt.rise) begin
                    bit_cnt <= bit_cnt + 4'd1;
                    shift   <= rx_byte;
                    if (state == ST_RD_ACK) begin
                        master_ack <= ~evt.sda;
                    end
                    if (bus_we) begin
                        wr_stb  <= 1'b1;
                        wr_addr <= ptr;
                        wr_data <= rx_byte;
                        ptr     <= ptr + 1'b1;
                    end
                end
                if (evt.fall) begin
                    case (state)
                        ST_ADDR: begin
                            if (bit_cnt == 4'd8) begin
                                bit_cnt <= 4'd0;
                                if (addr_match(shift, DEV_ADDR)) begin
                                    state  <= ST_ADDR_ACK;
                                    rw     <= shift[0];
                                    sda_oe <= 1'b1;
                                    busy   <= 1'b1;
                                end else begin
                                    state <= ST_IDLE;
                                    busy  <= 1'b0;
                                end
                            end
                        end
                        ST_ADDR_ACK: begin
                            if (bit_cnt == 4'd1) begin
                                bit_cnt <= 4'd0;
                                if (rw) begin
                                    state    <= ST_RD_BYTE;
                                    rd_shift <= rd_val;
                                    sda_oe   <= ~rd_val[7];
                                    ptr      <= ptr + 1'b1;
                                end else begin
                                    state  <= ST_PTR;
                                    sda_oe <= 1'b0;
                                end
                            end
                        end
                        ST_PTR: begin
                            if (bit_cnt == 4'd8) begin
                                bit_cnt <= 4'd0;
                                ptr     <= shift[AW-1:0];
                                sda_oe  <= 1'b1;
                                state   <= ST_PTR_ACK;
                            end
                        end
                        ST_PTR_ACK, ST_WR_ACK: begin
                            if (bit_cnt == 4'd1) begin
                                bit_cnt <= 4'd0;
                                sda_oe  <= 1'b0;
                                state   <= ST_WR_BYTE;
                            end
                        end
                        ST_WR_BYTE: begin
                            if (bit_cnt == 4'd8) begin
                                bit_cnt <= 4'd0;
                                sda_oe  <= 1'b1;
                                state   <= ST_WR_ACK;
                            end
                        end
                        ST_RD_BYTE: begin
                            if (bit_cnt == 4'd8) begin
                                bit_cnt <= 4'd0;
                                sda_oe  <= 1'b0;
                                state   <= ST_RD_ACK;
                            end else begin
                                rd_shift <= {rd_shift[6:0], 1'b0};
                                sda_oe   <= ~rd_shift[6];
                            end
                        end
                        ST_RD_ACK: begin
                            if (bit_cnt == 4'd1) begin
                                bit_cnt <= 4'd0;
                                if (master_ack) begin
                                    state    <= ST_RD_BYTE;
                                    rd_shift <= rd_val;
                                    sda_oe   <= ~rd_val[7];
                                    ptr      <= ptr + 1'b1;
                                end else begin
                                    state  <= ST_WAIT;
                                    sda_oe <= 1'b0;
                                end
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_mpu6050_i2c_target.sv
// Bench for mpu6050_i2c_target: a bit-banged I2C master drives the bus,
// a register-map model predicts writes and read bytes, and a monitor
// process compares DUT strobes and received bytes against queued expectations.
module tb_mpu6050_i2c_target;
    import mpu6050_pkg::*;

    localparam int Q = 100;

    logic       mclk = 1'b0;
    logic       reset;
    logic       scl_m;
    logic       sda_m;
    logic       sda_line;
    logic       sda_oe;
    logic       upd_en;
    logic [6:0] upd_addr;
    logic [7:0] upd_data;
    logic       wr_stb;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;

    int total = 0;
    int bad   = 0;

    logic [7:0]  model [128];
    int          mptr;
    logic [14:0] wr_exp [$];
    logic [7:0]  rd_exp [$];
    logic [7:0]  rd_obs [$];
    logic [7:0]  wdata  [$];

    assign sda_line = sda_m & ~sda_oe;

    always #5 mclk = ~mclk;

    mpu6050_i2c_target dut (
        .mclk     (mclk),
        .reset    (reset),
        .scl      (scl_m),
        .sda_in   (sda_line),
        .sda_oe   (sda_oe),
        .upd_en   (upd_en),
        .upd_addr (upd_addr),
        .upd_data (upd_data),
        .wr_stb   (wr_stb),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Register-map model: what an MPU6050 register interface should do
    task automatic modelReset();
        for (int i = 0; i < 128; i++) model[i] = 8'h00;
        mptr = 0;
    endtask

    task automatic modelWrite(input logic [7:0] d);
        wr_exp.push_back({7'(mptr), d});
        if (mptr != 'h75) model[mptr] = d;
        mptr = (mptr + 1) % 128;
    endtask

    function automatic logic [7:0] modelRead();
        logic [7:0] v;
        v = (mptr == 'h75) ? 8'h68 : model[mptr];
        mptr = (mptr + 1) % 128;
        return v;
    endfunction

    task automatic monitor();
        logic [14:0] e;
        logic [7:0]  o;
        forever begin
            @(negedge mclk);
            if (reset && wr_stb) begin
                if (wr_exp.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_wr_stb actual=%0h:%0h expected=none", wr_addr, wr_data);
                end else begin
                    e = wr_exp.pop_front();
                    checkOutput("wr_addr", int'(wr_addr), int'(e[14:8]));
                    checkOutput("wr_data", int'(wr_data), int'(e[7:0]));
                end
            end
            if (rd_obs.size() > 0) begin
                o = rd_obs.pop_front();
                if (rd_exp.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_rd_byte actual=%0h expected=none", o);
                end else begin
                    checkOutput("rd_byte", int'(o), int'(rd_exp.pop_front()));
                end
            end
        end
    endtask

    // Bit-level master primitives
    task automatic startCond();
        sda_m = 1'b1; #Q;
        scl_m = 1'b1; #Q;
        sda_m = 1'b0; #Q;
        scl_m = 1'b0; #Q;
    endtask

    task automatic stopCond();
        sda_m = 1'b0; #Q;
        scl_m = 1'b1; #Q;
        sda_m = 1'b1; #Q;
    endtask

    task automatic sendBit(input logic b);
        sda_m = b; #Q;
        scl_m = 1'b1; #(2*Q);
        scl_m = 1'b0; #Q;
    endtask

    task automatic recvBit(output logic b);
        sda_m = 1'b1; #Q;
        scl_m = 1'b1; #Q;
        b = sda_line; #Q;
        scl_m = 1'b0; #Q;
    endtask

    task automatic sendByte(input logic [7:0] d, output logic acked);
        logic b;
        for (int i = 7; i >= 0; i--) sendBit(d[i]);
        recvBit(b);
        acked = ~b;
    endtask

    task automatic recvByte(input logic nack, output logic [7:0] d);
        logic b;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            recvBit(b);
            d = {d[6:0], b};
        end
        sendBit(nack);
    endtask

    // Transaction-level stimulus
    task automatic applyStimulusUpd(input logic [6:0] a, input logic [7:0] d);
        @(negedge mclk);
        upd_en = 1'b1; upd_addr = a; upd_data = d;
        @(negedge mclk);
        upd_en = 1'b0;
        if (a != 7'h75) model[a] = d;
    endtask

    task automatic applyStimulusWrite(input logic [6:0] p);
        logic acked;
        startCond();
        sendByte(8'hD0, acked);
        checkOutput("ack_addr_w", int'(acked), 1);
        sendByte({1'($urandom_range(0, 1)), p}, acked);
        checkOutput("ack_ptr", int'(acked), 1);
        mptr = int'(p);
        foreach (wdata[i]) begin
            modelWrite(wdata[i]);
            sendByte(wdata[i], acked);
            checkOutput("ack_data", int'(acked), 1);
        end
        checkOutput("busy_frame", int'(busy), 1);
        stopCond();
        checkOutput("busy_after_stop", int'(busy), 0);
    endtask

    task automatic applyStimulusRead(input logic [6:0] p, input int n);
        logic       acked;
        logic [7:0] d;
        startCond();
        sendByte(8'hD0, acked);
        checkOutput("ack_addr_w", int'(acked), 1);
        sendByte({1'b0, p}, acked);
        checkOutput("ack_ptr", int'(acked), 1);
        mptr = int'(p);
        startCond();
        sendByte(8'hD1, acked);
        checkOutput("ack_addr_r", int'(acked), 1);
        for (int i = 0; i < n; i++) begin
            rd_exp.push_back(modelRead());
            recvByte((i == n - 1), d);
            rd_obs.push_back(d);
        end
        checkOutput("sda_released_after_nack", int'(sda_oe), 0);
        checkOutput("busy_frame", int'(busy), 1);
        stopCond();
        checkOutput("busy_after_stop", int'(busy), 0);
    endtask

    initial begin
        logic       acked;
        logic [6:0] p;
        int         n;
        reset = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
        upd_en = 1'b0; upd_addr = 7'h00; upd_data = 8'h00;
        modelReset();
        fork
            monitor();
        join_none
        repeat (5) @(negedge mclk);
        reset = 1'b1;
        repeat (3) @(negedge mclk);
        checkOutput("reset_sda_oe", int'(sda_oe), 0);
        checkOutput("reset_wr_stb", int'(wr_stb), 0);
        checkOutput("reset_wr_addr", int'(wr_addr), 0);
        checkOutput("reset_wr_data", int'(wr_data), 0);
        checkOutput("reset_busy", int'(busy), 0);
        #Q;

        // Power-management write
        wdata = '{8'h00};
        applyStimulusWrite(PWR_MGMT_1);

        // WHO_AM_I read
        applyStimulusRead(7'h75, 1);

        // Sensor-side refresh then burst read of the accelerometer block
        for (int i = 0; i < 6; i++) applyStimulusUpd(ACCEL_XOUT_H + 7'(i), 8'(8'h11 * (i + 1)));
        applyStimulusRead(ACCEL_XOUT_H, 6);

        // Wrong address is ignored entirely
        startCond();
        sendByte(8'hD2, acked);
        checkOutput("nack_wrong_addr", int'(acked), 0);
        checkOutput("busy_wrong_addr", int'(busy), 0);
        sendByte(8'h55, acked);
        checkOutput("nack_after_mismatch", int'(acked), 0);
        stopCond();

        // Pointer wrap on write and read
        wdata = '{8'hA5, 8'h5A};
        applyStimulusWrite(7'h7F);
        applyStimulusRead(7'h7F, 2);

        // Reset while the target drives a zero bit
        wdata = '{8'h00};
        applyStimulusWrite(7'h20);
        startCond();
        sendByte(8'hD0, acked);
        sendByte(8'h20, acked);
        startCond();
        sendByte(8'hD1, acked);
        checkOutput("ack_before_reset", int'(acked), 1);
        scl_m = 1'b1; #Q;
        checkOutput("oe_before_reset", int'(sda_oe), 1);
        reset = 1'b0; #1;
        checkOutput("oe_during_reset", int'(sda_oe), 0);
        checkOutput("busy_during_reset", int'(busy), 0);
        #50;
        scl_m = 1'b0; #Q;
        reset = 1'b1;
        modelReset();
        #Q;
        stopCond();
        applyStimulusRead(7'h7F, 1);
        wdata = '{8'hC3};
        applyStimulusWrite(7'h10);
        applyStimulusRead(7'h10, 1);

        // Randomised mix of writes, reads and local updates
        for (int it = 0; it < 14; it++) begin
            p = ($urandom_range(0, 5) == 0) ? 7'h75 : 7'($urandom_range(0, 127));
            n = $urandom_range(1, 4);
            case ($urandom_range(0, 2))
                0: applyStimulusUpd(p, 8'($urandom_range(0, 255)));
                1: begin
                    wdata.delete();
                    for (int k = 0; k < n; k++) wdata.push_back(8'($urandom_range(0, 255)));
                    applyStimulusWrite(p);
                end
                default: applyStimulusRead(p, n);
            endcase
        end

        repeat (20) @(negedge mclk);
        checkOutput("wr_queue_drained", wr_exp.size(), 0);
        checkOutput("rd_queue_drained", rd_exp.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
